// File: rtl/ascon_cmd_sequencer_pkg.sv
// Shared constants for the Ascon command sequencer: opcodes, bdi types, INS word layout and FSM states.
package ascon_cmd_sequencer_pkg;

    localparam int unsigned INS_OP_LSB    = 28;
    localparam int unsigned INS_FLAGS_LSB = 24;
    localparam int unsigned INS_LEN_W     = 24;

    localparam logic [3:0] OP_LD_KEY   = 4'h1;
    localparam logic [3:0] OP_LD_NONCE = 4'h2;
    localparam logic [3:0] OP_LD_AD    = 4'h3;
    localparam logic [3:0] OP_LD_PT    = 4'h4;
    localparam logic [3:0] OP_LD_CT    = 4'h5;
    localparam logic [3:0] OP_LD_TAG   = 4'h6;
    localparam logic [3:0] OP_DO_ENC   = 4'h8;
    localparam logic [3:0] OP_DO_DEC   = 4'h9;
    localparam logic [3:0] OP_DO_HASH  = 4'hA;

    localparam logic [3:0] D_NULL  = 4'h0;
    localparam logic [3:0] D_NONCE = 4'h1;
    localparam logic [3:0] D_AD    = 4'h2;
    localparam logic [3:0] D_PTCT  = 4'h3;
    localparam logic [3:0] D_TAG   = 4'h4;

    typedef enum logic [1:0] {S_INS, S_DAT, S_DROP} seq_state_e;

    // ceil(len/4) without a wider intermediate
    function automatic logic [INS_LEN_W-1:0] word_count(input logic [INS_LEN_W-1:0] len);
        return {2'b00, len[INS_LEN_W-1:2]} + {{(INS_LEN_W-1){1'b0}}, |len[1:0]};
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LD_KEY) && (op <= OP_LD_TAG);
    endfunction

    function automatic logic [3:0] bdi_type_of(input logic [3:0] op);
        logic [3:0] t;
        case (op)
            OP_LD_NONCE:         t = D_NONCE;
            OP_LD_AD:            t = D_AD;
            OP_LD_PT, OP_LD_CT:  t = D_PTCT;
            OP_LD_TAG:           t = D_TAG;
            default:             t = D_NULL;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/ascon_cmd_sequencer_if.sv
// Command stream, masked key/bdi ports and mode lines between sequencer (master) and core/feeder (slave).
interface ascon_cmd_sequencer_if #(
    parameter int unsigned NUM_SHARES = 2,
    parameter int unsigned CCW        = 32,
    parameter int unsigned CCSW       = 32
);
    logic [31:0]              cmd_data;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [NUM_SHARES*CCSW-1:0] key;
    logic                     key_valid;
    logic                     key_ready;
    logic [NUM_SHARES*CCW-1:0] bdi;
    logic                     bdi_valid;
    logic                     bdi_ready;
    logic [3:0]               bdi_type;
    logic                     bdi_eot;
    logic                     bdi_eoi;
    logic                     decrypt;
    logic                     hash;
    logic                     cmd_err;

    modport master (
        input  cmd_data, cmd_valid, key_ready, bdi_ready,
        output cmd_ready, key, key_valid, bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi,
               decrypt, hash, cmd_err
    );

    modport slave (
        output cmd_data, cmd_valid, key_ready, bdi_ready,
        input  cmd_ready, key, key_valid, bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi,
               decrypt, hash, cmd_err
    );
endinterface

// File: rtl/sca_prng.sv
// xorshift32 mask generator; state is the output and advances once per enabled cycle.
module sca_prng #(
    parameter logic [31:0] SEED = 32'h1234_5679
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [31:0] rnd
);
    logic [31:0] state_q;
    logic [31:0] s1, s2, s3;

    always_comb begin
        s1 = state_q ^ (state_q << 13);
        s2 = s1 ^ (s1 >> 17);
        s3 = s2 ^ (s2 << 5);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else if (en) begin
            state_q <= s3;
        end
    end

    assign rnd = state_q;
endmodule

// File: rtl/ascon_cmd_sequencer.sv
// Decodes INS/DAT command words and emits Boolean-masked key/bdi words plus mode lines to the core.
module ascon_cmd_sequencer
    import ascon_cmd_sequencer_pkg::*;
#(
    parameter int unsigned NUM_SHARES = 2,
    parameter int unsigned CCW        = 32,
    parameter int unsigned CCSW       = 32,
    parameter logic [31:0] PRNG_SEED  = 32'h1234_5679
) (
    input logic              clk,
    input logic              rst_n,
    ascon_cmd_sequencer_if.master bus
);
    seq_state_e                 state_q;
    logic [INS_LEN_W-1:0]       wcnt_q;
    logic                       eoi_flag_q;
    logic                       sel_key_q;
    logic [3:0]                 type_q;
    logic                       buf_valid_q;
    logic                       eot_q;
    logic                       eoi_q;
    logic [NUM_SHARES*CCW-1:0]  shares_q;
    logic                       decrypt_q;
    logic                       hash_q;
    logic                       err_q;

    logic [3:0]                 op;
    logic [INS_LEN_W-1:0]       ins_wcnt;
    logic                       drain;
    logic                       cmd_ready;
    logic                       accept;
    logic                       prng_en;
    logic [CCW-1:0]             rnd [1:NUM_SHARES-1];
    logic [CCW-1:0]             share0;
    logic [NUM_SHARES*CCW-1:0]  masked;

    assign op       = bus.cmd_data[INS_OP_LSB +: 4];
    assign ins_wcnt = word_count(bus.cmd_data[INS_LEN_W-1:0]);
    assign drain    = buf_valid_q & (sel_key_q ? bus.key_ready : bus.bdi_ready);

    always_comb begin
        cmd_ready = 1'b0;
        case (state_q)
            S_INS:   cmd_ready = ~buf_valid_q;
            S_DAT:   cmd_ready = ~buf_valid_q | drain;
            S_DROP:  cmd_ready = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
        cmd_ready = cmd_ready & rst_n;
    end

    assign accept  = bus.cmd_valid & cmd_ready;
    assign prng_en = accept & (state_q == S_DAT);

    for (genvar g = 1; g < NUM_SHARES; g++) begin : g_prng
        sca_prng #(
            .SEED (PRNG_SEED + 32'(g))
        ) u_prng (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (prng_en),
            .rnd   (rnd[g])
        );
    end

    // Share 0 absorbs every mask so the XOR over all shares recovers the DAT word.
    always_comb begin
        masked = '0;
        share0 = bus.cmd_data[CCW-1:0];
        for (int i = 1; i < NUM_SHARES; i++) begin
            masked[i*CCW +: CCW] = rnd[i];
            share0 = share0 ^ rnd[i];
        end
        masked[CCW-1:0] = share0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INS;
            wcnt_q      <= '0;
            eoi_flag_q  <= 1'b0;
            sel_key_q   <= 1'b0;
            type_q      <= D_NULL;
            buf_valid_q <= 1'b0;
            eot_q       <= 1'b0;
            eoi_q       <= 1'b0;
            shares_q    <= '0;
            decrypt_q   <= 1'b0;
            hash_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (drain) begin
                buf_valid_q <= 1'b0;
            end
            case (state_q)
                S_INS: begin
                    if (accept) begin
                        if (op == OP_DO_ENC) begin
                            decrypt_q <= 1'b0;
                            hash_q    <= 1'b0;
                        end else if (op == OP_DO_DEC) begin
                            decrypt_q <= 1'b1;
                            hash_q    <= 1'b0;
                        end else if (op == OP_DO_HASH) begin
                            decrypt_q <= 1'b0;
                            hash_q    <= 1'b1;
                        end else if (is_load(op)) begin
                            sel_key_q  <= (op == OP_LD_KEY);
                            type_q     <= bdi_type_of(op);
                            eoi_flag_q <= bus.cmd_data[INS_FLAGS_LSB];
                            wcnt_q     <= ins_wcnt;
                            if (ins_wcnt != '0) begin
                                state_q <= S_DAT;
                            end
                        end else begin
                            err_q  <= 1'b1;
                            wcnt_q <= ins_wcnt;
                            if (ins_wcnt != '0) begin
                                state_q <= S_DROP;
                            end
                        end
                    end
                end
                S_DAT: begin
                    if (accept) begin
                        buf_valid_q <= 1'b1;
                        shares_q    <= masked;
                        eot_q       <= (wcnt_q == 1);
                        eoi_q       <= (wcnt_q == 1) & eoi_flag_q;
                        wcnt_q      <= wcnt_q - 1'b1;
                        if (wcnt_q == 1) begin
                            state_q <= S_INS;
                        end
                    end
                end
                S_DROP: begin
                    if (accept) begin
                        wcnt_q <= wcnt_q - 1'b1;
                        if (wcnt_q == 1) begin
                            state_q <= S_INS;
                        end
                    end
                end
                default: state_q <= S_INS;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.key_valid = buf_valid_q & sel_key_q;
    assign bus.bdi_valid = buf_valid_q & ~sel_key_q;
    assign bus.key       = (buf_valid_q & sel_key_q) ? shares_q : '0;
    assign bus.bdi       = (buf_valid_q & ~sel_key_q) ? shares_q : '0;
    assign bus.bdi_type  = (buf_valid_q & ~sel_key_q) ? type_q : D_NULL;
    assign bus.bdi_eot   = buf_valid_q & eot_q;
    assign bus.bdi_eoi   = buf_valid_q & eoi_q;
    assign bus.decrypt   = decrypt_q;
    assign bus.hash      = hash_q;
    assign bus.cmd_err   = err_q;

endmodule
